// File: rtl/spectrum_read_arbiter.sv
// Round-robin arbiter sharing the FFT-magnitude buffer read port between two burst readers.
// A grant owns the port for one burst; hold_fft freezes the FFT writer until the burst is retired.
module spectrum_read_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] start0,
  input  logic [ADDR_W:0]   len0,
  output logic              gnt0,
  output logic              rd_valid0,
  output logic [DATA_W-1:0] rd_data0,
  output logic              done0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] start1,
  input  logic [ADDR_W:0]   len1,
  output logic              gnt1,
  output logic              rd_valid1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              done1,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  input  logic              fft_busy,
  output logic              hold_fft,
  output logic              overlap
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic              sel;
  logic              rr_ptr;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt;
  logic [1:0]        dcnt;
  logic              gnt_q;
  logic              done_q;
  logic              ram_rd_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              overlap_q;
  logic [RD_LAT-1:0] vld_pipe;

  logic              win;
  logic [ADDR_W-1:0] win_start;
  logic [ADDR_W:0]   win_len;
  logic [ADDR_W:0]   clamp_len;
  logic              rd_valid;

  // Contention goes to rr_ptr; a lone requester always wins.
  assign win       = (req0 && req1) ? rr_ptr : req1;
  assign win_start = win ? start1 : start0;
  assign win_len   = win ? len1 : len0;
  assign clamp_len = (win_len > DEPTH) ? DEPTH : win_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      rr_ptr     <= 1'b0;
      len_q      <= '0;
      cnt        <= '0;
      dcnt       <= '0;
      gnt_q      <= 1'b0;
      done_q     <= 1'b0;
      ram_rd_q   <= 1'b0;
      ram_addr_q <= '0;
      overlap_q  <= 1'b0;
      vld_pipe   <= '0;
    end else begin
      if (fft_busy && (state == BURST || state == DRAIN))
        overlap_q <= 1'b1;

      vld_pipe[0] <= ram_rd_q;
      for (int k = 1; k < RD_LAT; k++)
        vld_pipe[k] <= vld_pipe[k-1];

      case (state)
        IDLE: begin
          if ((req0 || req1) && !fft_busy) begin
            sel        <= win;
            len_q      <= clamp_len;
            gnt_q      <= 1'b1;
            ram_addr_q <= win_start;
            cnt        <= (ADDR_W+1)'(1);
            if (clamp_len == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state    <= BURST;
              ram_rd_q <= 1'b1;
            end
          end
        end
        BURST: begin
          if (cnt == len_q) begin
            ram_rd_q <= 1'b0;
            dcnt     <= 2'd1;
            state    <= DRAIN;
          end else begin
            ram_addr_q <= ram_addr_q + ADDR_W'(1);
            cnt        <= cnt + (ADDR_W+1)'(1);
          end
        end
        DRAIN: begin
          if (dcnt == 2'(RD_LAT)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            dcnt <= dcnt + 2'd1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          gnt_q  <= 1'b0;
          rr_ptr <= ~sel;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The last byte lands before DONE, so sel still names its owner.
  assign rd_valid  = vld_pipe[RD_LAT-1];
  assign rd_valid0 = rd_valid & ~sel;
  assign rd_valid1 = rd_valid & sel;
  assign rd_data0  = rd_valid0 ? ram_data : '0;
  assign rd_data1  = rd_valid1 ? ram_data : '0;

  assign gnt0     = gnt_q & ~sel;
  assign gnt1     = gnt_q & sel;
  assign done0    = done_q & ~sel;
  assign done1    = done_q & sel;
  assign hold_fft = gnt_q;
  assign ram_rd   = ram_rd_q;
  assign ram_addr = ram_addr_q;
  assign overlap  = overlap_q;

endmodule

// File: tb/tb_spectrum_read_arbiter.sv
// Bench for spectrum_read_arbiter: table of burst requests plus directed busy/overlap/reset sequences.
module tb_spectrum_read_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int RL = 1;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [AW-1:0] start0, start1;
  logic [AW:0]   len0, len1;
  logic          gnt0, gnt1, rd_valid0, rd_valid1, done0, done1;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          fft_busy, hold_fft, overlap;

  spectrum_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .start0(start0), .len0(len0), .gnt0(gnt0),
    .rd_valid0(rd_valid0), .rd_data0(rd_data0), .done0(done0),
    .req1(req1), .start1(start1), .len1(len1), .gnt1(gnt1),
    .rd_valid1(rd_valid1), .rd_data1(rd_data1), .done1(done1),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_data(ram_data),
    .fft_busy(fft_busy), .hold_fft(hold_fft), .overlap(overlap)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done0_n = 0;
  int done1_n = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] dpipe [RL];
  int            addr_q [$];
  logic [DW-1:0] b0_q [$];
  logic [DW-1:0] b1_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    dpipe[0] <= mem[ram_addr];
    for (int k = 1; k < RL; k++) dpipe[k] <= dpipe[k-1];
  end
  assign ram_data = dpipe[RL-1];

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void expect_burst(input int w, input int start, input int len);
    int l;
    l = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < l; i++) begin
      int a;
      a = (start + i) % DEPTH;
      addr_q.push_back(a);
      if (w == 0) b0_q.push_back(mem[a]);
      else        b1_q.push_back(mem[a]);
    end
  endfunction

  // Scoreboard: every read address and every returned byte is checked against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_rd) begin
        check("ram_rd_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) check("ram_addr", ram_addr, addr_q.pop_front());
      end
      check("valid_exclusive", rd_valid0 & rd_valid1, 0);
      if (rd_valid0) begin
        check("rd_valid0_expected", b0_q.size() > 0, 1);
        if (b0_q.size() > 0) check("rd_data0", rd_data0, b0_q.pop_front());
      end else begin
        check("rd_data0_idle", rd_data0, 0);
      end
      if (rd_valid1) begin
        check("rd_valid1_expected", b1_q.size() > 0, 1);
        if (b1_q.size() > 0) check("rd_data1", rd_data1, b1_q.pop_front());
      end else begin
        check("rd_data1_idle", rd_data1, 0);
      end
      if (done0) done0_n++;
      if (done1) done1_n++;
    end
  end

  task automatic wait_done(input int w, output int dc);
    dc = -1;
    for (int n = 0; n < 3000; n++) begin
      if ((w == 0 ? done0 : done1) === 1'b1) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", dc >= 0, 1);
  endtask

  // Called at #1 after the edge that opens IDLE cycle t with the request already driven.
  task automatic serve(input int w, input int t, input int len);
    int l, dc, exp_dc;
    l = (len > DEPTH) ? DEPTH : len;
    exp_dc = (l == 0) ? 1 : l + RL + 1;
    @(negedge clk);
    check("gnt_idle_before", {gnt0, gnt1, hold_fft}, 0);
    @(negedge clk);
    check("gnt_win", (w == 0) ? gnt0 : gnt1, 1);
    check("gnt_lose", (w == 0) ? gnt1 : gnt0, 0);
    check("hold_on", hold_fft, 1);
    check("ram_rd_first", ram_rd, l != 0);
    wait_done(w, dc);
    check("done_cycle", dc - t, exp_dc);
    check("gnt_at_done", (w == 0) ? gnt0 : gnt1, 1);
    @(posedge clk); #1;
    if (w == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  typedef struct {
    bit r0;
    bit r1;
    int s0;
    int l0;
    int s1;
    int l1;
    int first;
  } vec_t;

  initial begin
    vec_t vt [7];
    int t, dc, n0, f, o;

    vt[0] = '{1, 1,   10,    3,   20, 2, 0};
    vt[1] = '{1, 0,    5,    4,    0, 0, 0};
    vt[2] = '{1, 1,  600,    2,  610, 3, 1};
    vt[3] = '{0, 1,    0,    0, 1020, 8, 1};
    vt[4] = '{1, 0,  700, 2000,    0, 0, 0};
    vt[5] = '{0, 1,    0,    0,  123, 0, 1};
    vt[6] = '{1, 1, 1023,    2,    9, 1, 0};

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 37 + 11);

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; fft_busy = 1'b0;
    start0 = '0; start1 = '0; len0 = '0; len1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {gnt0, gnt1, hold_fft}, 0);
    check("rst_done", {done0, done1}, 0);
    check("rst_ram_rd", ram_rd, 0);
    check("rst_valid", {rd_valid0, rd_valid1}, 0);
    check("rst_overlap", overlap, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      start0 = AW'(vt[v].s0); len0 = 11'(vt[v].l0);
      start1 = AW'(vt[v].s1); len1 = 11'(vt[v].l1);
      req0 = vt[v].r0; req1 = vt[v].r1;
      f = vt[v].first;
      o = 1 - f;
      expect_burst(f, (f == 1) ? vt[v].s1 : vt[v].s0, (f == 1) ? vt[v].l1 : vt[v].l0);
      if (vt[v].r0 && vt[v].r1)
        expect_burst(o, (o == 1) ? vt[v].s1 : vt[v].s0, (o == 1) ? vt[v].l1 : vt[v].l0);
      serve(f, cyc, (f == 1) ? vt[v].l1 : vt[v].l0);
      if (vt[v].r0 && vt[v].r1)
        serve(o, cyc, (o == 1) ? vt[v].l1 : vt[v].l0);
      @(negedge clk);
      check("gnt_off_after", {gnt0, gnt1, hold_fft}, 0);
      check("addr_q_empty", addr_q.size(), 0);
      check("b0_q_empty", b0_q.size(), 0);
      check("b1_q_empty", b1_q.size(), 0);
      @(posedge clk); #1;
    end

    // Writer busy while idle: grant waits, and overlap must not fire.
    fft_busy = 1'b1; req0 = 1'b1; start0 = 10'd50; len0 = 11'd2;
    repeat (5) begin
      @(negedge clk);
      check("gnt0_blocked", gnt0, 0);
    end
    @(posedge clk); #1;
    fft_busy = 1'b0;
    expect_burst(0, 50, 2);
    serve(0, cyc, 2);
    check("overlap_idle_busy", overlap, 0);

    // Busy pulse mid-burst; req and inputs change mid-burst and are ignored.
    repeat (2) @(posedge clk); #1;
    req1 = 1'b1; start1 = 10'd300; len1 = 11'd6;
    expect_burst(1, 300, 6);
    t = cyc;
    @(posedge clk); #1;
    fft_busy = 1'b1; req1 = 1'b0; start1 = '0; len1 = 11'd1;
    @(posedge clk); #1;
    fft_busy = 1'b0;
    @(negedge clk);
    check("overlap_set", overlap, 1);
    check("gnt1_mid_burst", gnt1, 1);
    wait_done(1, dc);
    check("t5_done_cycle", dc - t, 6 + RL + 1);
    repeat (5) @(negedge clk);
    check("overlap_sticky", overlap, 1);
    check("t5_queue_empty", addr_q.size() + b1_q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("overlap_cleared", overlap, 0);

    // Reset in the middle of a burst aborts it without a done pulse.
    @(posedge clk); #1;
    req0 = 1'b1; start0 = '0; len0 = 11'd20;
    expect_burst(0, 0, 20);
    repeat (5) @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0;
    n0 = done0_n;
    @(posedge clk); #1;
    rst = 1'b0;
    addr_q.delete(); b0_q.delete(); b1_q.delete();
    @(negedge clk);
    check("abort_gnt", {gnt0, gnt1, hold_fft}, 0);
    check("abort_ram_rd", ram_rd, 0);
    check("abort_valid", {rd_valid0, rd_valid1}, 0);
    check("abort_done", {done0, done1}, 0);
    repeat (10) @(negedge clk);
    check("abort_no_done", done0_n, n0);
    @(posedge clk); #1;
    req0 = 1'b1; start0 = 10'd77; len0 = 11'd0;
    serve(0, cyc, 0);
    @(negedge clk);
    check("len0_back_idle", {gnt0, gnt1, hold_fft}, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
